// File: rtl/xnor_corr_pkg.sv
// Shared types and helpers for the XNOR sync-word correlator.
package xnor_corr_pkg;

    // Frame-alignment state; encodings are visible on the state output port.
    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } corr_state_e;

    // Bits needed to hold an agreeing-bit count of 0..pat_w.
    function automatic int score_width(input int pat_w);
        return $clog2(pat_w + 1);
    endfunction

endpackage

// File: rtl/xnor_popcount.sv
// Combinational population count of the XNOR agreement vector.
module xnor_popcount
    import xnor_corr_pkg::*;
#(
    parameter int PAT_W = 16,
    parameter int SW    = score_width(PAT_W)
) (
    input  logic [PAT_W-1:0] vec,
    output logic [SW-1:0]    count
);

    // Sum the set bits of the agreement vector.
    always_comb begin
        count = '0;
        for (int i = 0; i < PAT_W; i++) begin
            count = count + SW'(vec[i]);
        end
    end

endmodule

// File: rtl/xnor_sync_correlator.sv
// Serial sync-word correlator with SEARCH/VERIFY/LOCKED frame alignment.
// Optional macro SYNC_INV_DETECT_EN adds inverted-polarity acquisition;
// without it inv stays 0 and only true polarity is detected.
module xnor_sync_correlator
    import xnor_corr_pkg::*;
#(
    parameter int               PAT_W     = 16,
    parameter logic [PAT_W-1:0] SYNC_PAT  = PAT_W'(16'hA5C3),
    parameter int               THRESH    = 16,
    parameter int               FRAME_LEN = 64,
    parameter int               CONFIRM   = 2,
    parameter int               MISS_MAX  = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          bit_in,
    input  logic                          bit_vld,
    output logic [score_width(PAT_W)-1:0] score,
    output logic                          match,
    output logic                          frame_start,
    output logic                          locked,
    output logic [1:0]                    state,
    output logic                          inv
);

    localparam int SW = score_width(PAT_W);
    localparam int PW = $clog2(FRAME_LEN);
    localparam int HW = $clog2(CONFIRM + 1);
    localparam int MW = $clog2(MISS_MAX + 1);

    logic [PAT_W-1:0] sr_r, sr_s, xnor_s;
    logic [SW-1:0]    fill_r, fill_s, score_r, new_score_s;
    logic [PW-1:0]    pos_r, pos_s;
    logic [HW-1:0]    hits_r, hits_s;
    logic [MW-1:0]    miss_r, miss_s;
    corr_state_e      state_r, state_s;
    logic             match_r, match_s, fs_r, fs_s, locked_r;
    logic             inv_r, inv_s;
    logic             full_s, true_hit_s, hit_s, check_s;

    assign sr_s   = {sr_r[PAT_W-2:0], bit_in};
    assign xnor_s = ~(sr_s ^ SYNC_PAT);

    xnor_popcount #(.PAT_W(PAT_W), .SW(SW)) u_popcount (
        .vec   (xnor_s),
        .count (new_score_s)
    );

    assign full_s     = (int'(fill_r) + 1) >= PAT_W;
    assign true_hit_s = full_s && (int'(new_score_s) >= THRESH);
    assign check_s    = (int'(pos_r) + 1) == FRAME_LEN;
    assign fill_s     = (int'(fill_r) >= PAT_W) ? fill_r : fill_r + SW'(1);

`ifdef SYNC_INV_DETECT_EN
    logic inv_hit_s;
    assign inv_hit_s = full_s && ((PAT_W - int'(new_score_s)) >= THRESH);

    // SEARCH accepts either polarity; tracking states use the latched one.
    always_comb begin
        if (state_r == SEARCH) begin
            hit_s = true_hit_s || inv_hit_s;
        end else if (inv_r) begin
            hit_s = inv_hit_s;
        end else begin
            hit_s = true_hit_s;
        end
    end
`else
    assign hit_s = true_hit_s;
`endif

    // Next-state and counter update for the accepted bit, using pre-update counters.
    always_comb begin
        state_s = state_r;
        pos_s   = check_s ? '0 : pos_r + PW'(1);
        hits_s  = hits_r;
        miss_s  = miss_r;
        inv_s   = inv_r;
        fs_s    = 1'b0;
        match_s = hit_s;
        case (state_r)
            SEARCH: begin
                if (hit_s) begin
                    pos_s  = '0;
                    hits_s = HW'(1);
`ifdef SYNC_INV_DETECT_EN
                    inv_s  = ~true_hit_s;
`else
                    inv_s  = 1'b0;
`endif
                    if (CONFIRM == 1) begin
                        state_s = LOCKED;
                        miss_s  = '0;
                    end else begin
                        state_s = VERIFY;
                    end
                end else begin
                    state_s = SEARCH;
                end
            end
            VERIFY: begin
                if (check_s && hit_s) begin
                    hits_s = hits_r + HW'(1);
                    if ((int'(hits_r) + 1) >= CONFIRM) begin
                        state_s = LOCKED;
                        miss_s  = '0;
                    end else begin
                        state_s = VERIFY;
                    end
                end else if (check_s) begin
                    state_s = SEARCH;
                    hits_s  = '0;
                    inv_s   = 1'b0;
                end else begin
                    state_s = VERIFY;
                end
            end
            LOCKED: begin
                if (check_s && hit_s) begin
                    miss_s = '0;
                    fs_s   = 1'b1;
                end else if (check_s && ((int'(miss_r) + 1) >= MISS_MAX)) begin
                    state_s = SEARCH;
                    miss_s  = '0;
                    hits_s  = '0;
                    inv_s   = 1'b0;
                end else if (check_s) begin
                    miss_s = miss_r + MW'(1);
                    fs_s   = 1'b1;
                end else begin
                    state_s = LOCKED;
                end
            end
            default: begin
                state_s = SEARCH;
                pos_s   = '0;
                hits_s  = '0;
                miss_s  = '0;
                inv_s   = 1'b0;
                match_s = 1'b0;
            end
        endcase
    end

    // State, window and output registers; only accepted bits advance anything.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sr_r     <= '0;
            fill_r   <= '0;
            pos_r    <= '0;
            hits_r   <= '0;
            miss_r   <= '0;
            state_r  <= SEARCH;
            score_r  <= '0;
            match_r  <= 1'b0;
            fs_r     <= 1'b0;
            locked_r <= 1'b0;
            inv_r    <= 1'b0;
        end else if (bit_vld) begin
            sr_r     <= sr_s;
            fill_r   <= fill_s;
            pos_r    <= pos_s;
            hits_r   <= hits_s;
            miss_r   <= miss_s;
            state_r  <= state_s;
            score_r  <= new_score_s;
            match_r  <= match_s;
            fs_r     <= fs_s;
            locked_r <= (state_s == LOCKED);
            inv_r    <= inv_s;
        end else begin
            match_r <= 1'b0;
            fs_r    <= 1'b0;
        end
    end

    assign score       = score_r;
    assign match       = match_r;
    assign frame_start = fs_r;
    assign locked      = locked_r;
    assign state       = state_r;
    assign inv         = inv_r;

endmodule
